// File: rtl/progressive_counter.sv
// Count-up seconds timer: counts whole seconds up to a 4-bit target while start is held.
// Optional macro PROGRESSIVE_COUNTER_AUTO_RESTART_EN re-arms the timer one second after DONE.
module progressive_counter #(
    parameter int CLOCK_FREQ = 50_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] seconds_target,
    output logic [6:0] hex5_seconds_elapsed,
    output logic       ledr9_finished,
    output logic [1:0] db_state
);

    localparam int PW = (CLOCK_FREQ > 1) ? $clog2(CLOCK_FREQ) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLOCK_FREQ - 1);

    localparam logic [1:0] IDLE     = 2'b00;
    localparam logic [1:0] COUNTING = 2'b01;
    localparam logic [1:0] PAUSED   = 2'b10;
    localparam logic [1:0] DONE     = 2'b11;

    logic [1:0]    state_q, state_d;
    logic [3:0]    count_q, count_d;
    logic [3:0]    target_q, target_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          finished_q, finished_d;
    logic          pre_run;
    logic          tick;

    // Valid/ready style handshakes do not apply here; start is a plain level enable.
`ifdef PROGRESSIVE_COUNTER_AUTO_RESTART_EN
    assign pre_run = (state_q == COUNTING) || ((state_q == DONE) && start);
`else
    assign pre_run = (state_q == COUNTING);
`endif
    assign tick = pre_run && (pre_q == PRE_MAX);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        target_d   = target_q;
        finished_d = finished_q;
        pre_d      = pre_q;
        if (pre_run) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                target_d   = seconds_target;
                count_d    = '0;
                pre_d      = '0;
                finished_d = 1'b0;
                if (start) begin
                    if (seconds_target != 4'd0) begin
                        state_d = COUNTING;
                    end else begin
                        state_d    = DONE;
                        finished_d = 1'b1;
                    end
                end
            end
            COUNTING: begin
                // A tick coinciding with start falling is still taken before pausing.
                if (tick) begin
                    count_d = count_q + 4'd1;
                end
                if (tick && (count_q + 4'd1 == target_q)) begin
                    state_d    = DONE;
                    finished_d = 1'b1;
                end else if (!start) begin
                    state_d = PAUSED;
                end
            end
            PAUSED: begin
                if (start) begin
                    state_d = COUNTING;
                end
            end
            DONE: begin
`ifdef PROGRESSIVE_COUNTER_AUTO_RESTART_EN
                if (tick) begin
                    count_d    = '0;
                    finished_d = 1'b0;
                    state_d    = COUNTING;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            target_q   <= '0;
            pre_q      <= '0;
            finished_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            target_q   <= target_d;
            pre_q      <= pre_d;
            finished_q <= finished_d;
        end
    end

    function automatic logic [6:0] hexa7seg(input logic [3:0] v);
        case (v)
            4'h0:    hexa7seg = 7'b1000000;
            4'h1:    hexa7seg = 7'b1111001;
            4'h2:    hexa7seg = 7'b0100100;
            4'h3:    hexa7seg = 7'b0110000;
            4'h4:    hexa7seg = 7'b0011001;
            4'h5:    hexa7seg = 7'b0010010;
            4'h6:    hexa7seg = 7'b0000010;
            4'h7:    hexa7seg = 7'b1111000;
            4'h8:    hexa7seg = 7'b0000000;
            4'h9:    hexa7seg = 7'b0010000;
            4'hA:    hexa7seg = 7'b0001000;
            4'hB:    hexa7seg = 7'b0000011;
            4'hC:    hexa7seg = 7'b1000110;
            4'hD:    hexa7seg = 7'b0100001;
            4'hE:    hexa7seg = 7'b0000110;
            default: hexa7seg = 7'b0001110;
        endcase
    endfunction

    assign hex5_seconds_elapsed = hexa7seg(count_q);
    assign ledr9_finished       = finished_q;
    assign db_state             = state_q;

endmodule

// File: tb/tb_progressive_counter.sv
// Directed bench for progressive_counter with CLOCK_FREQ=4: a per-cycle vector table
// plus hand-written pause/resume, reset, target-change and DONE sequences.
module tb_progressive_counter;

    localparam logic [6:0] H0 = 7'b1000000;
    localparam logic [6:0] H1 = 7'b1111001;
    localparam logic [6:0] H2 = 7'b0100100;
    localparam logic [6:0] H3 = 7'b0110000;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] seconds_target;
    logic [6:0] hex;
    logic       fin;
    logic [1:0] st;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       rst;
        logic       st;
        logic [3:0] tgt;
        logic [6:0] hex;
        logic       fin;
        logic [1:0] state;
    } vec_t;

    vec_t vq[$];

    progressive_counter #(.CLOCK_FREQ(4)) dut (
        .clock                (clk),
        .reset                (reset),
        .start                (start),
        .seconds_target       (seconds_target),
        .hex5_seconds_elapsed (hex),
        .ledr9_finished       (fin),
        .db_state             (st)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        step();
        reset = 1'b0;
    endtask

    initial begin
        int n;
        int k;
        int f;
        reset = 1'b1;
        start = 1'b0;
        seconds_target = 4'd0;

        // target 3 held start: ticks every 4 cycles, DONE at count 3; then target 0.
        vq.push_back('{1'b1, 1'b0, 4'd0, H0, 1'b0, 2'b00});
        vq.push_back('{1'b0, 1'b1, 4'd3, H0, 1'b0, 2'b01});
        vq.push_back('{1'b0, 1'b1, 4'd3, H0, 1'b0, 2'b01});
        vq.push_back('{1'b0, 1'b1, 4'd3, H0, 1'b0, 2'b01});
        vq.push_back('{1'b0, 1'b1, 4'd3, H0, 1'b0, 2'b01});
        vq.push_back('{1'b0, 1'b1, 4'd3, H1, 1'b0, 2'b01});
        vq.push_back('{1'b0, 1'b1, 4'd3, H1, 1'b0, 2'b01});
        vq.push_back('{1'b0, 1'b1, 4'd3, H1, 1'b0, 2'b01});
        vq.push_back('{1'b0, 1'b1, 4'd3, H1, 1'b0, 2'b01});
        vq.push_back('{1'b0, 1'b1, 4'd3, H2, 1'b0, 2'b01});
        vq.push_back('{1'b0, 1'b1, 4'd3, H2, 1'b0, 2'b01});
        vq.push_back('{1'b0, 1'b1, 4'd3, H2, 1'b0, 2'b01});
        vq.push_back('{1'b0, 1'b1, 4'd3, H2, 1'b0, 2'b01});
        vq.push_back('{1'b0, 1'b1, 4'd3, H3, 1'b1, 2'b11});
        vq.push_back('{1'b0, 1'b0, 4'd3, H3, 1'b1, 2'b11});
        vq.push_back('{1'b1, 1'b0, 4'd3, H0, 1'b0, 2'b00});
        vq.push_back('{1'b0, 1'b1, 4'd0, H0, 1'b1, 2'b11});
        vq.push_back('{1'b0, 1'b0, 4'd5, H0, 1'b1, 2'b11});
        vq.push_back('{1'b1, 1'b0, 4'd5, H0, 1'b0, 2'b00});
        vq.push_back('{1'b0, 1'b0, 4'd5, H0, 1'b0, 2'b00});

        for (int i = 0; i < vq.size(); i++) begin
            reset          = vq[i].rst;
            start          = vq[i].st;
            seconds_target = vq[i].tgt;
            step();
            check($sformatf("vec%0d_hex", i), 8'(hex), 8'(vq[i].hex));
            check($sformatf("vec%0d_fin", i), 8'(fin), 8'(vq[i].fin));
            check($sformatf("vec%0d_state", i), 8'(st), 8'(vq[i].state));
        end

        // Pause at count 1 for 10 start-low cycles, resume, finish after 12 COUNTING cycles.
        do_reset();
        seconds_target = 4'd3;
        start = 1'b1;
        step();
        check("pause_entry_state", 8'(st), 8'(2'b01));
        repeat (6) step();
        check("pause_pre_hex", 8'(hex), 8'(H1));
        start = 1'b0;
        step();
        check("pause_state", 8'(st), 8'(2'b10));
        for (int i = 0; i < 9; i++) begin
            step();
            check($sformatf("pause_hold_state%0d", i), 8'(st), 8'(2'b10));
            check($sformatf("pause_hold_hex%0d", i), 8'(hex), 8'(H1));
        end
        start = 1'b1;
        step();
        check("resume_state", 8'(st), 8'(2'b01));
        n = 7;
        k = 0;
        while (!fin && k < 30) begin
            if (st == 2'b01) n++;
            step();
            k++;
        end
        check("pause_fin", 8'(fin), 8'd1);
        check("pause_counting_cycles", 8'(n), 8'd12);
        check("pause_final_hex", 8'(hex), 8'(H3));

        // Reset while counting at count 2.
        do_reset();
        seconds_target = 4'd5;
        start = 1'b1;
        step();
        k = 0;
        while (hex != H2 && k < 30) begin
            step();
            k++;
        end
        check("rst_reach_count2", 8'(hex), 8'(H2));
        reset = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b0;
        check("rst_hex", 8'(hex), 8'(H0));
        check("rst_fin", 8'(fin), 8'd0);
        check("rst_state", 8'(st), 8'(2'b00));

        // Target latched at 3; later change to 5 must be ignored.
        do_reset();
        seconds_target = 4'd3;
        start = 1'b1;
        step();
        seconds_target = 4'd5;
        n = 0;
        k = 0;
        while (!fin && k < 40) begin
            if (st == 2'b01) n++;
            step();
            k++;
        end
        check("tchg_fin", 8'(fin), 8'd1);
        check("tchg_hex", 8'(hex), 8'(H3));
        check("tchg_cycles", 8'(n), 8'd12);

`ifdef PROGRESSIVE_COUNTER_AUTO_RESTART_EN
        // Auto restart: finish lasts 4 start-high cycles, then counts to 2 again.
        do_reset();
        seconds_target = 4'd2;
        start = 1'b1;
        step();
        k = 0;
        while (!fin && k < 30) begin
            step();
            k++;
        end
        check("ar_fin1", 8'(fin), 8'd1);
        check("ar_hex1", 8'(hex), 8'(H2));
        f = 0;
        while (fin && f < 20) begin
            f++;
            step();
        end
        check("ar_fin_len", 8'(f), 8'd4);
        check("ar_restart_hex", 8'(hex), 8'(H0));
        check("ar_restart_state", 8'(st), 8'(2'b01));
        k = 0;
        while (!fin && k < 30) begin
            step();
            k++;
        end
        check("ar_fin2", 8'(fin), 8'd1);
        check("ar_hex2", 8'(hex), 8'(H2));
`else
        // DONE is terminal: start held and target changes do not move it.
        do_reset();
        seconds_target = 4'd1;
        start = 1'b1;
        step();
        k = 0;
        while (!fin && k < 30) begin
            step();
            k++;
        end
        check("term_fin_reached", 8'(fin), 8'd1);
        seconds_target = 4'd7;
        f = 0;
        repeat (10) begin
            step();
            if (fin) f++;
        end
        check("term_fin_held", 8'(f), 8'd10);
        check("term_state", 8'(st), 8'(2'b11));
        check("term_hex", 8'(hex), 8'(H1));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
